// File: rtl/conv3d_pkg.sv
// conv3d_pkg: shared state encoding, read-region codes and phase selection for the conv3d fetch path
package conv3d_pkg;
    localparam int CNT_W = 18;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_X = 3'd1;
    localparam logic [2:0] ST_RD_Y = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic RD_SEL_X = 1'b0;
    localparam logic RD_SEL_Y = 1'b1;
    // First phase, in X -> Y -> Z order, whose count is still nonzero; DONE when none remain.
    function automatic logic [2:0] first_phase(input logic x_nz, input logic y_nz, input logic z_nz);
        return x_nz ? ST_RD_X : y_nz ? ST_RD_Y : z_nz ? ST_WR : ST_DONE;
    endfunction
endpackage

// File: rtl/conv3d_addr_cnt.sv
// conv3d_addr_cnt: address/down-counter pair for one region (load base and count, step on ack).
// Ports: clk, rst (sync, active-high); load_i/base_i/count_i load a new region;
// step_i advances address by one and decrements the count; addr_o current address,
// nz_o count nonzero, last_o exactly one word remaining.
module conv3d_addr_cnt import conv3d_pkg::*; #(
    parameter int AW = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [AW-1:0]    base_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             step_i,
    output logic [AW-1:0]    addr_o,
    output logic             nz_o,
    output logic             last_o
);
    logic [AW-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        addr_d = load_i ? base_i : step_i ? addr_q + AW'(1) : addr_q;
        cnt_d  = load_i ? count_i : step_i ? cnt_q - CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end
    assign addr_o = addr_q;
    assign nz_o   = cnt_q != '0;
    assign last_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/conv3d_fetch_ctrl.sv
// conv3d_fetch_ctrl: per-pass execution controller streaming feature/weight reads then output writes.
// Ports: clk, rst (sync, active-high); param_* latched on param_ena in IDLE;
// rd_req/rd_addr/rd_sel with rd_ack and wr_req/wr_addr with wr_ack form the memory handshake;
// busy (not IDLE), cur_height_out (latched height), start_drop (param_ena ignored this cycle),
// flag_write_over (one-cycle pass-complete pulse).
module conv3d_fetch_ctrl import conv3d_pkg::*; #(
    parameter int AW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          param_ena,
    input  logic [AW-1:0] param_xaddr,
    input  logic [AW-1:0] param_yaddr,
    input  logic [AW-1:0] param_zaddr,
    input  logic [8:0]    param_width_in,
    input  logic [8:0]    param_height_out,
    input  logic [17:0]   param_length_in,
    input  logic [17:0]   param_length_out,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    output logic          rd_sel,
    input  logic          rd_ack,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    input  logic          wr_ack,
    output logic          busy,
    output logic [8:0]    cur_height_out,
    output logic          start_drop,
    output logic          flag_write_over
);
    logic [2:0]    state_q, state_d;
    logic [8:0]    height_q, height_d;
    logic          start;
    logic          x_step, y_step, z_step;
    logic          x_nz, y_nz, z_nz;
    logic          x_last, y_last, z_last;
    logic [AW-1:0] x_addr, y_addr, z_addr;

    assign start  = param_ena && state_q == ST_IDLE;
    // An exhausted counter never steps, so a stray ack cannot underflow it.
    assign x_step = state_q == ST_RD_X && rd_ack && x_nz;
    assign y_step = state_q == ST_RD_Y && rd_ack && y_nz;
    assign z_step = state_q == ST_WR && wr_ack && z_nz;

    conv3d_addr_cnt #(.AW(AW)) u_x (
        .clk(clk), .rst(rst), .load_i(start), .base_i(param_xaddr),
        .count_i(param_length_in), .step_i(x_step),
        .addr_o(x_addr), .nz_o(x_nz), .last_o(x_last)
    );
    conv3d_addr_cnt #(.AW(AW)) u_y (
        .clk(clk), .rst(rst), .load_i(start), .base_i(param_yaddr),
        .count_i(CNT_W'(param_width_in)), .step_i(y_step),
        .addr_o(y_addr), .nz_o(y_nz), .last_o(y_last)
    );
    conv3d_addr_cnt #(.AW(AW)) u_z (
        .clk(clk), .rst(rst), .load_i(start), .base_i(param_zaddr),
        .count_i(param_length_out), .step_i(z_step),
        .addr_o(z_addr), .nz_o(z_nz), .last_o(z_last)
    );

    always_comb begin
        state_d  = state_q;
        height_d = start ? param_height_out : height_q;
        case (state_q)
            ST_IDLE: if (param_ena) state_d = first_phase(|param_length_in, |param_width_in, |param_length_out);
            ST_RD_X: if (x_step && x_last) state_d = first_phase(1'b0, y_nz, z_nz);
            ST_RD_Y: if (y_step && y_last) state_d = first_phase(1'b0, 1'b0, z_nz);
            ST_WR:   if (z_step && z_last) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            height_q <= '0;
        end else begin
            state_q  <= state_d;
            height_q <= height_d;
        end
    end

    assign rd_req          = state_q == ST_RD_X || state_q == ST_RD_Y;
    assign rd_sel          = state_q == ST_RD_Y ? RD_SEL_Y : RD_SEL_X;
    assign rd_addr         = state_q == ST_RD_Y ? y_addr : state_q == ST_RD_X ? x_addr : '0;
    assign wr_req          = state_q == ST_WR;
    assign wr_addr         = state_q == ST_WR ? z_addr : '0;
    assign busy            = state_q != ST_IDLE;
    assign cur_height_out  = height_q;
    assign start_drop      = param_ena && state_q != ST_IDLE;
    assign flag_write_over = state_q == ST_DONE;
endmodule

// File: tb/tb_conv3d_fetch_ctrl.sv
// tb_conv3d_fetch_ctrl: randomized self-checking bench with a transfer-list reference model
module tb_conv3d_fetch_ctrl;
    localparam int AW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          param_ena = 1'b0;
    logic [AW-1:0] px = '0, py = '0, pz = '0;
    logic [8:0]    pw = '0, ph = '0;
    logic [17:0]   pli = '0, plo = '0;
    logic          rd_ack = 1'b0, wr_ack = 1'b0;
    logic          rd_req, rd_sel, wr_req, busy, start_drop, flag_write_over;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [8:0]    cur_height_out;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct packed {
        logic          w;
        logic          sel;
        logic [AW-1:0] a;
    } xfer_t;

    conv3d_fetch_ctrl #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .param_ena(param_ena),
        .param_xaddr(px), .param_yaddr(py), .param_zaddr(pz),
        .param_width_in(pw), .param_height_out(ph),
        .param_length_in(pli), .param_length_out(plo),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_ack(rd_ack),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .busy(busy), .cur_height_out(cur_height_out),
        .start_drop(start_drop), .flag_write_over(flag_write_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (got hang, expected finish)");
        $fatal(1, "global timeout");
    end

    function automatic logic [AW-1:0] rnd_addr();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Starts a pass in the current cycle and follows it against the expected transfer list.
    // Returns at the first cycle after the flag (the earliest legal restart), or at abort_at.
    task automatic run_pass(input logic [AW-1:0] x, input logic [AW-1:0] y, input logic [AW-1:0] z,
                            input int li, input int wi, input int lo, input int h, input bit rnd,
                            input int nack_from, input int nack_len, input int drop_at,
                            input int abort_at, output int flag_cyc);
        xfer_t q[$];
        xfer_t hd;
        logic  ra, wa;
        for (int i = 0; i < li; i++) begin hd = {1'b0, 1'b0, x + AW'(i)}; q.push_back(hd); end
        for (int i = 0; i < wi; i++) begin hd = {1'b0, 1'b1, y + AW'(i)}; q.push_back(hd); end
        for (int i = 0; i < lo; i++) begin hd = {1'b1, 1'b0, z + AW'(i)}; q.push_back(hd); end
        flag_cyc = -1;
        px = x; py = y; pz = z; pli = 18'(li); pw = 9'(wi); plo = 18'(lo); ph = 9'(h);
        param_ena = 1'b1; rd_ack = 1'b0; wr_ack = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if ({busy, start_drop, flag_write_over, rd_req, wr_req} !== 5'b0) begin
            err_cnt++;
            $display("FAIL start_idle: busy/drop/flag/rd/wr=%b expected 00000",
                     {busy, start_drop, flag_write_over, rd_req, wr_req});
        end
        @(posedge clk); #1;
        param_ena = 1'b0;
        for (int c = 1; c < 400; c++) begin
            if (c == abort_at) return;
            ra = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wa = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c >= nack_from && c < nack_from + nack_len) ra = 1'b0;
            rd_ack = ra; wr_ack = wa;
            param_ena = (c == drop_at);
            if (c == drop_at) begin
                px = rnd_addr(); py = rnd_addr(); pz = rnd_addr();
                pli = 18'($urandom); pw = 9'($urandom); plo = 18'($urandom); ph = ~9'(h);
            end
            @(negedge clk);
            cmp_cnt++;
            if (start_drop !== (c == drop_at)) begin
                err_cnt++;
                $display("FAIL start_drop c=%0d: got %b expected %b", c, start_drop, c == drop_at);
            end
            cmp_cnt++;
            if (cur_height_out !== 9'(h)) begin
                err_cnt++;
                $display("FAIL height c=%0d: got %0d expected %0d", c, cur_height_out, h);
            end
            if (q.size() == 0) begin
                cmp_cnt++;
                if ({flag_write_over, busy, rd_req, wr_req} !== 4'b1100) begin
                    err_cnt++;
                    $display("FAIL done c=%0d: flag/busy/rd/wr=%b expected 1100",
                             c, {flag_write_over, busy, rd_req, wr_req});
                end
                flag_cyc = c;
                @(posedge clk); #1;
                rd_ack = 1'b0; wr_ack = 1'b0; param_ena = 1'b0;
                return;
            end
            hd = q[0];
            cmp_cnt++;
            if ({rd_req, wr_req, busy, flag_write_over, hd.w ? wr_addr : rd_addr, hd.w ? 1'b0 : rd_sel} !==
                {~hd.w, hd.w, 1'b1, 1'b0, hd.a, hd.w ? 1'b0 : hd.sel}) begin
                err_cnt++;
                $display("FAIL xfer c=%0d: rd=%b wr=%b busy=%b flag=%b sel=%b rda=%h wra=%h expected w=%b sel=%b addr=%h",
                         c, rd_req, wr_req, busy, flag_write_over, rd_sel, rd_addr, wr_addr, hd.w, hd.sel, hd.a);
            end
            if (hd.w ? wa : ra) void'(q.pop_front());
            @(posedge clk); #1;
        end
        cmp_cnt++; err_cnt++;
        $display("FAIL pass_timeout: got no flag within 400 cycles, expected flag after %0d transfers left", q.size());
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_ack = 1'b1; wr_ack = 1'b1; param_ena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        cmp_cnt++;
        if ({rd_req, rd_sel, rd_addr, wr_req, wr_addr, busy, cur_height_out, start_drop, flag_write_over} !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: rd=%b sel=%b rda=%h wr=%b wra=%h busy=%b h=%0d drop=%b flag=%b expected all 0",
                     rd_req, rd_sel, rd_addr, wr_req, wr_addr, busy, cur_height_out, start_drop, flag_write_over);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if ({rd_req, wr_req, busy, flag_write_over} !== 4'b0) begin
            err_cnt++;
            $display("FAIL idle_ack_ignored: rd/wr/busy/flag=%b expected 0000",
                     {rd_req, wr_req, busy, flag_write_over});
        end
        @(posedge clk); #1;
        rd_ack = 1'b0; wr_ack = 1'b0;
    endtask

    task automatic test_basic();
        int fc;
        run_pass(AW'(32'h100), AW'(32'h200), AW'(32'h300), 4, 2, 3, 7, 1'b0, 0, 0, 0, 0, fc);
        cmp_cnt++;
        if (fc !== 10) begin err_cnt++; $display("FAIL basic_flag_cycle: got %0d expected 10", fc); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int fc;
        run_pass(AW'(32'h100), AW'(32'h200), AW'(32'h300), 4, 2, 3, 9, 1'b0, 2, 3, 0, 0, fc);
        cmp_cnt++;
        if (fc !== 13) begin err_cnt++; $display("FAIL backpressure_flag_cycle: got %0d expected 13", fc); end
    endtask

    task automatic test_zero_counts();
        int fc;
        run_pass(rnd_addr(), rnd_addr(), rnd_addr(), 3, 0, 2, 1, 1'b1, 0, 0, 0, 0, fc);
        run_pass(rnd_addr(), rnd_addr(), rnd_addr(), 0, 0, 0, 2, 1'b0, 0, 0, 0, 0, fc);
        cmp_cnt++;
        if (fc !== 1) begin err_cnt++; $display("FAIL all_zero_flag_cycle: got %0d expected 1", fc); end
        run_pass(rnd_addr(), rnd_addr(), rnd_addr(), 0, 0, 2, 3, 1'b0, 0, 0, 0, 0, fc);
        cmp_cnt++;
        if (fc !== 3) begin err_cnt++; $display("FAIL wr_only_flag_cycle: got %0d expected 3", fc); end
        run_pass(rnd_addr(), rnd_addr(), rnd_addr(), 0, 3, 0, 4, 1'b0, 0, 0, 0, 0, fc);
        cmp_cnt++;
        if (fc !== 4) begin err_cnt++; $display("FAIL y_only_flag_cycle: got %0d expected 4", fc); end
    endtask

    task automatic test_start_busy();
        int fc;
        run_pass(rnd_addr(), rnd_addr(), rnd_addr(), 2, 1, 4, 11, 1'b0, 0, 0, 5, 0, fc);
        cmp_cnt++;
        if (fc !== 8) begin err_cnt++; $display("FAIL drop_flag_cycle: got %0d expected 8", fc); end
        @(negedge clk);
        cmp_cnt++;
        if ({flag_write_over, busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL single_flag: flag/busy=%b expected 00", {flag_write_over, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int fc;
        run_pass(rnd_addr(), rnd_addr(), rnd_addr(), 1, 1, 3, 13, 1'b0, 0, 0, 0, 4, fc);
        rst = 1'b1; wr_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmp_cnt++;
            if ({rd_req, rd_sel, rd_addr, wr_req, wr_addr, busy, cur_height_out, start_drop, flag_write_over} !== '0) begin
                err_cnt++;
                $display("FAIL reset_mid k=%0d: rd=%b wr=%b wra=%h busy=%b h=%0d flag=%b expected all 0",
                         k, rd_req, wr_req, wr_addr, busy, cur_height_out, flag_write_over);
            end
            @(posedge clk); #1;
        end
        run_pass(rnd_addr(), rnd_addr(), rnd_addr(), 3, 2, 3, 14, 1'b1, 0, 0, 0, 0, fc);
    endtask

    task automatic test_scheduler_loop();
        int fc;
        logic [AW-1:0] x0, y0, z0;
        x0 = rnd_addr(); y0 = rnd_addr(); z0 = rnd_addr();
        run_pass(x0, y0, z0, 3, 2, 2, 5, 1'b0, 0, 0, 0, 0, fc);
        cmp_cnt++;
        if (fc !== 8) begin err_cnt++; $display("FAIL loop_first_flag: got %0d expected 8", fc); end
        run_pass(x0 + AW'(3), y0, z0 + AW'(2), 3, 2, 2, 5, 1'b0, 0, 0, 0, 0, fc);
        cmp_cnt++;
        if (fc !== 8) begin err_cnt++; $display("FAIL loop_second_flag: got %0d expected 8", fc); end
    endtask

    task automatic test_wrap();
        int fc;
        run_pass({AW{1'b1}} - AW'(1), {AW{1'b1}}, {AW{1'b1}} - AW'(2), 4, 3, 5, 6, 1'b1, 0, 0, 0, 0, fc);
    endtask

    task automatic test_random();
        int fc, drop;
        for (int n = 0; n < 40; n++) begin
            drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
            run_pass(rnd_addr(), rnd_addr(), rnd_addr(), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 511)), 1'b1, 0, 0, drop, 0, fc);
            if ($urandom_range(0, 1) == 1) begin
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_counts();
        test_start_busy();
        test_reset_mid();
        test_scheduler_loop();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
